// File: rtl/dma_mem_slave.sv
// DMA slave memory model: parametrised depth/width, independent read/write wait states,
// half-word write enables, priority wait bypass and error response on unmapped addresses.
module dma_mem_slave #(
  parameter int DATA      = 16,
  parameter int ADD       = 4,
  parameter int MEM_SIZE  = 16,
  parameter int RD_WAIT   = 4,
  parameter int WR_WAIT   = 3,
  parameter int INIT_BASE = 'h20
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            dma_en,
  input  logic [ADD-1:0]  dma_addr,
  input  logic [DATA-1:0] dma_din,
  input  logic [1:0]      dma_we,
  input  logic            dma_priority,
  output logic            dma_ready,
  output logic            dma_resp,
  output logic [DATA-1:0] dma_out
);

  localparam int          DEPTH       = 2**ADD;
  localparam int          HALF        = DATA / 2;
  localparam logic [3:0]  LP_RD_WAIT  = 4'(RD_WAIT);
  localparam logic [3:0]  LP_WR_WAIT  = 4'(WR_WAIT);
  localparam logic [ADD:0] LP_MEM_SIZE = (ADD+1)'(MEM_SIZE);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t          r_state;
  logic [3:0]      r_cnt;
  logic [1:0]      r_we;
  logic [DATA-1:0] r_mem [DEPTH];

  logic [3:0]      w_wait;
  logic            w_unmapped;

  // Wait count chosen at request sampling; priority bypasses all wait states.
  assign w_wait     = dma_priority ? 4'd0 : ((dma_we == 2'b00) ? LP_RD_WAIT : LP_WR_WAIT);
  assign w_unmapped = ({1'b0, dma_addr} >= LP_MEM_SIZE);

  // Request FSM, registered handshake outputs and the memory array.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 4'd0;
      r_we      <= 2'b00;
      dma_ready <= 1'b0;
      dma_resp  <= 1'b0;
      dma_out   <= {DATA{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= DATA'(INIT_BASE + i);
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          dma_ready <= 1'b0;
          dma_resp  <= 1'b0;
          if (dma_en) begin
            r_we  <= dma_we;
            r_cnt <= w_wait;
            if (w_wait == 4'd0) begin
              r_state   <= ST_ACK;
              dma_ready <= 1'b1;
              dma_resp  <= w_unmapped;
            end else begin
              r_state <= ST_WAIT;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (!dma_en) begin
            // Master withdrew the request: abort silently.
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
          end else if (r_cnt == 4'd1) begin
            r_state   <= ST_ACK;
            r_cnt     <= 4'd0;
            dma_ready <= 1'b1;
            dma_resp  <= w_unmapped;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_ACK: begin
          r_state   <= ST_IDLE;
          dma_ready <= 1'b0;
          dma_resp  <= 1'b0;
          if (dma_en) begin
            if (r_we == 2'b00) begin
              dma_out <= w_unmapped ? {DATA{1'b0}} : r_mem[dma_addr];
            end else if (!w_unmapped) begin
              if (r_we[1]) begin
                r_mem[dma_addr][DATA-1:HALF] <= dma_din[DATA-1:HALF];
              end
              if (r_we[0]) begin
                r_mem[dma_addr][HALF-1:0] <= dma_din[HALF-1:0];
              end
            end
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_cnt     <= 4'd0;
          dma_ready <= 1'b0;
          dma_resp  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dma_mem_slave.sv
// Self-checking bench for dma_mem_slave: directed scenarios plus randomized accesses
// compared against a behavioural memory/latency model.
module tb_dma_mem_slave;

  logic        clk;
  logic        reset;
  logic        dma_en;
  logic [3:0]  dma_addr;
  logic [15:0] dma_din;
  logic [1:0]  dma_we;
  logic        dma_priority;
  logic        dma_ready;
  logic        dma_resp;
  logic [15:0] dma_out;

  int          checks;
  int          failures;
  int          cyc;
  int          last_ready_cyc;
  logic [15:0] mem_m [16];
  logic [15:0] exp_out;

  dma_mem_slave #(
    .DATA(16), .ADD(4), .MEM_SIZE(12), .RD_WAIT(4), .WR_WAIT(3), .INIT_BASE('h20)
  ) dut (
    .clk(clk), .reset(reset), .dma_en(dma_en), .dma_addr(dma_addr), .dma_din(dma_din),
    .dma_we(dma_we), .dma_priority(dma_priority), .dma_ready(dma_ready),
    .dma_resp(dma_resp), .dma_out(dma_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter used to measure spacing between acknowledges.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mem_m[i] = 16'(32'h20 + i);
    exp_out = 16'h0000;
  endtask

  // One request issued at a negedge with DUT idle; abort_at >= 0 drops dma_en
  // at that many negedges after the sampling edge.
  task automatic access(input logic [3:0] a, input logic [15:0] d, input logic [1:0] we,
                        input logic pri, input int abort_at);
    int   w;
    int   n;
    logic unm;
    logic seen;
    w   = pri ? 0 : ((we == 2'b00) ? 4 : 3);
    unm = (a >= 4'd12);
    dma_en = 1'b1; dma_addr = a; dma_din = d; dma_we = we; dma_priority = pri;
    if (abort_at >= 0) begin
      n = 0;
      seen = 1'b0;
      @(negedge clk);
      while (n < abort_at) begin
        if (dma_ready) seen = 1'b1;
        n++;
        @(negedge clk);
      end
      if (dma_ready) seen = 1'b1;
      dma_en = 1'b0;
      repeat (w + 3) begin
        @(negedge clk);
        if (dma_ready) seen = 1'b1;
      end
      check_eq("abort_no_ready", {31'd0, seen}, 32'd0);
      check_eq("abort_out_hold", {16'd0, dma_out}, {16'd0, exp_out});
    end else begin
      n = 0;
      @(negedge clk);
      while (!dma_ready && n < 40) begin
        n++;
        @(negedge clk);
      end
      check_eq("ready_latency", n, w);
      check_eq("resp_with_ready", {31'd0, dma_resp}, {31'd0, unm});
      last_ready_cyc = cyc;
      if (we == 2'b00) begin
        exp_out = unm ? 16'h0000 : mem_m[a];
      end else if (!unm) begin
        if (we[1]) mem_m[a][15:8] = d[15:8];
        if (we[0]) mem_m[a][7:0]  = d[7:0];
      end
      @(negedge clk);
      check_eq("ready_one_cycle", {31'd0, dma_ready}, 32'd0);
      check_eq("resp_drop", {31'd0, dma_resp}, 32'd0);
      check_eq("dout", {16'd0, dma_out}, {16'd0, exp_out});
      dma_en = 1'b0;
    end
  endtask

  initial begin
    int first_cyc;
    int w;
    int ab;
    logic [1:0] we;
    logic pri;
    checks = 0; failures = 0; cyc = 0; last_ready_cyc = 0;
    reset = 1'b0; dma_en = 1'b0; dma_addr = 4'd0; dma_din = 16'd0;
    dma_we = 2'b00; dma_priority = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("rst_ready", {31'd0, dma_ready}, 32'd0);
    check_eq("rst_resp", {31'd0, dma_resp}, 32'd0);
    check_eq("rst_out", {16'd0, dma_out}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // 1: plain read after reset
    access(4'd5, 16'h0000, 2'b00, 1'b0, -1);
    check_eq("s1_read5", {16'd0, dma_out}, 32'h0025);

    // 2: full write, readback, low-half write, readback
    access(4'd2, 16'hF50A, 2'b11, 1'b0, -1);
    access(4'd2, 16'h0000, 2'b00, 1'b0, -1);
    check_eq("s2_full_write", {16'd0, dma_out}, 32'hF50A);
    access(4'd2, 16'h1234, 2'b01, 1'b0, -1);
    access(4'd2, 16'h0000, 2'b00, 1'b0, -1);
    check_eq("s2_low_half", {16'd0, dma_out}, 32'hF534);

    // 3: priority reads back to back
    access(4'd0, 16'h0000, 2'b00, 1'b1, -1);
    check_eq("s3_prio_read0", {16'd0, dma_out}, 32'h0020);
    first_cyc = last_ready_cyc;
    access(4'd1, 16'h0000, 2'b00, 1'b1, -1);
    check_eq("s3_b2b_spacing", last_ready_cyc - first_cyc, 2);

    // 4: unmapped read and write
    access(4'd13, 16'h0000, 2'b00, 1'b0, -1);
    check_eq("s4_unmapped_out", {16'd0, dma_out}, 32'h0000);
    access(4'd13, 16'hBEEF, 2'b11, 1'b0, -1);
    for (int i = 0; i < 12; i += 3) access(4'(i), 16'h0000, 2'b00, 1'b0, -1);

    // 5: write aborted after one wait cycle
    access(4'd4, 16'hDEAD, 2'b11, 1'b0, 1);
    access(4'd4, 16'h0000, 2'b00, 1'b0, -1);
    check_eq("s5_abort_read4", {16'd0, dma_out}, 32'h0024);

    // 6: reset during the wait phase of a write
    access(4'd7, 16'h0000, 2'b00, 1'b0, -1);
    dma_en = 1'b1; dma_addr = 4'd1; dma_din = 16'hAAAA; dma_we = 2'b11; dma_priority = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("s6_rst_ready", {31'd0, dma_ready}, 32'd0);
    check_eq("s6_rst_resp", {31'd0, dma_resp}, 32'd0);
    check_eq("s6_rst_out", {16'd0, dma_out}, 32'd0);
    dma_en = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    access(4'd1, 16'h0000, 2'b00, 1'b0, -1);
    check_eq("s6_read1", {16'd0, dma_out}, 32'h0021);

    // Randomized traffic with occasional aborts and idle gaps
    for (int t = 0; t < 120; t++) begin
      we  = 2'($urandom_range(0, 3));
      pri = ($urandom_range(0, 4) == 0);
      w   = pri ? 0 : ((we == 2'b00) ? 4 : 3);
      ab  = -1;
      if (w > 0 && $urandom_range(0, 7) == 0) ab = $urandom_range(0, w - 1);
      access(4'($urandom_range(0, 15)), 16'($urandom), we, pri, ab);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    for (int i = 0; i < 12; i++) access(4'(i), 16'h0000, 2'b00, 1'b0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
